// File: rtl/alu4_seq_if.sv
// Command/response handshake bundle for the alu4_seq command sequencer.
// ALU_SEQ_ACC_EN adds the cmd_use_acc command bit.
interface alu4_seq_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [2:0] cmd_op;
`ifdef ALU_SEQ_ACC_EN
    logic       cmd_use_acc;
`endif
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_result;
    logic [3:0] rsp_flags;

`ifdef ALU_SEQ_ACC_EN
    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_use_acc, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_result, rsp_flags
    );
    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_use_acc, rsp_ready,
        output cmd_ready, rsp_valid, rsp_result, rsp_flags
    );
`else
    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_result, rsp_flags
    );
    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
        output cmd_ready, rsp_valid, rsp_result, rsp_flags
    );
`endif
endinterface

// File: rtl/alu4_seq.sv
// Sequencer driving a combinational alu4: accept command, hold operands SETTLE cycles, capture, respond.
// Optional accumulator operand source enabled by defining ALU_SEQ_ACC_EN.
module alu4_seq #(
    parameter int SETTLE = 1,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    alu4_seq_if.slave        bus,
    output logic [3:0]       o_alu_a,
    output logic [3:0]       o_alu_b,
    output logic [2:0]       o_alu_op,
    input  logic [3:0]       i_alu_result,
    input  logic             i_alu_c,
    input  logic             i_alu_n,
    input  logic             i_alu_z,
    input  logic             i_alu_v,
    output logic [3:0]       o_sticky_flags,
    input  logic             i_clr_sticky,
    output logic [CNT_W-1:0] o_op_count,
    output logic             o_busy
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [3:0] WAIT_LOAD = 4'(SETTLE - 1);

    logic [1:0] r_state;
    logic [3:0] r_wait_cnt;
    logic [3:0] r_rsp_result;
    logic [3:0] r_rsp_flags;
    logic       w_accept;
    logic       w_capture;
    logic       w_release;
    logic [3:0] w_flags;
    logic [3:0] w_next_a;

    assign w_flags   = {i_alu_c, i_alu_n, i_alu_z, i_alu_v};
    assign w_accept  = (r_state == S_IDLE) && bus.cmd_valid;
    assign w_capture = (r_state == S_EXEC) && (r_wait_cnt == 4'd0);
    assign w_release = (r_state == S_RESP) && bus.rsp_ready;

    assign bus.cmd_ready  = (r_state == S_IDLE);
    assign bus.rsp_valid  = (r_state == S_RESP);
    assign bus.rsp_result = r_rsp_result;
    assign bus.rsp_flags  = r_rsp_flags;
    assign o_busy         = (r_state != S_IDLE);

`ifdef ALU_SEQ_ACC_EN
    logic [3:0] r_acc;

    assign w_next_a = bus.cmd_use_acc ? r_acc : bus.cmd_a;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_acc <= 4'd0;
        end else if (w_capture) begin
            r_acc <= i_alu_result;
        end
    end
`else
    assign w_next_a = bus.cmd_a;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_wait_cnt   <= 4'd0;
            o_alu_a      <= 4'd0;
            o_alu_b      <= 4'd0;
            o_alu_op     <= 3'd0;
            r_rsp_result <= 4'd0;
            r_rsp_flags  <= 4'd0;
            o_op_count   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        o_alu_a    <= w_next_a;
                        o_alu_b    <= bus.cmd_b;
                        o_alu_op   <= bus.cmd_op;
                        r_wait_cnt <= WAIT_LOAD;
                        r_state    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (w_capture) begin
                        r_rsp_result <= i_alu_result;
                        r_rsp_flags  <= w_flags;
                        o_op_count   <= o_op_count + CNT_W'(1);
                        r_state      <= S_RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (w_release) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A clear coinciding with a capture discards the old history but keeps the new flags.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            o_sticky_flags <= 4'd0;
        end else if (w_capture) begin
            o_sticky_flags <= (i_clr_sticky ? 4'd0 : o_sticky_flags) | w_flags;
        end else if (i_clr_sticky) begin
            o_sticky_flags <= 4'd0;
        end
    end
endmodule

// File: tb/tb_alu4_seq.sv
// Scoreboard bench for alu4_seq with a behavioural alu4 attached to the alu_* ports.
// Directed steps use fixed expected values; the random phase uses the arithmetic reference model.
module tb_alu4_seq;
    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] alu_a, alu_b, alu_result, sticky_flags;
    logic [2:0] alu_op;
    logic       alu_c, alu_n, alu_z, alu_v;
    logic       clr_sticky;
    logic       busy;
    logic [7:0] op_count;

    always #5 clk = ~clk;

    alu4_seq_if bus();

    alu4_seq #(.SETTLE(1), .CNT_W(8)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .bus            (bus),
        .o_alu_a        (alu_a),
        .o_alu_b        (alu_b),
        .o_alu_op       (alu_op),
        .i_alu_result   (alu_result),
        .i_alu_c        (alu_c),
        .i_alu_n        (alu_n),
        .i_alu_z        (alu_z),
        .i_alu_v        (alu_v),
        .o_sticky_flags (sticky_flags),
        .i_clr_sticky   (clr_sticky),
        .o_op_count     (op_count),
        .o_busy         (busy)
    );

    typedef struct packed {
        logic [3:0] result;
        logic [3:0] flags;
    } rsp_t;

    rsp_t       expQ[$];
    rsp_t       lastRsp;
    rsp_t       aluOut;
    int         vectors = 0;
    int         miscompares = 0;
    logic [3:0] modelSticky = 4'd0;
    logic [7:0] modelCount = 8'd0;
    logic [3:0] accModel = 4'd0;
    int         readyMode = 0;
    logic       randBit = 1'b1;

    // alu4 behaviour from plain integer arithmetic; flags are {c,n,z,v}.
    function automatic rsp_t aluRef(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        rsp_t r;
        int   sa, sb, s;
        logic c, v;
        sa = int'($signed(a));
        sb = int'($signed(b));
        c = 1'b0;
        v = 1'b0;
        case (op)
            3'd0: r.result = ~a;
            3'd1: r.result = ~b;
            3'd2: r.result = a & b;
            3'd3: r.result = a | b;
            3'd4: r.result = a ^ b;
            3'd5: r.result = ~(a ^ b);
            3'd6: begin
                s = int'(a) + int'(b);
                r.result = 4'(s);
                c = (s > 15);
                v = (sa + sb > 7) || (sa + sb < -8);
            end
            default: begin
                s = int'(a) - int'(b);
                r.result = 4'(s);
                c = (int'(a) >= int'(b));
                v = (sa - sb > 7) || (sa - sb < -8);
            end
        endcase
        r.flags = {c, r.result[3], (r.result == 4'd0), v};
        return r;
    endfunction

    assign aluOut = aluRef(alu_a, alu_b, alu_op);
    assign alu_result = aluOut.result;
    assign {alu_c, alu_n, alu_z, alu_v} = aluOut.flags;

    assign bus.rsp_ready = (readyMode == 0) ? 1'b1 : (readyMode == 1) ? 1'b0 : randBit;

    always begin
        @(posedge clk);
        #1;
        randBit = 1'($urandom_range(0, 1));
    end

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: every response handshake pops the oldest expected entry.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
            if (expQ.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected rsp: got %0h/%0h, expected no response", bus.rsp_result, bus.rsp_flags);
            end else begin
                rsp_t e;
                e = expQ.pop_front();
                checkOutput("rsp_result", 16'(bus.rsp_result), 16'(e.result));
                checkOutput("rsp_flags", 16'(bus.rsp_flags), 16'(e.flags));
            end
            lastRsp = {bus.rsp_result, bus.rsp_flags};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resetModel();
        expQ.delete();
        modelSticky = 4'd0;
        modelCount  = 8'd0;
        accModel    = 4'd0;
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        resetModel();
    endtask

    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                                 input logic useAcc, input logic clrAtCapture);
        rsp_t       e;
        logic [3:0] effA;
        int         n;
        n = 0;
        bus.cmd_a  = a;
        bus.cmd_b  = b;
        bus.cmd_op = op;
`ifdef ALU_SEQ_ACC_EN
        bus.cmd_use_acc = useAcc;
        effA = useAcc ? accModel : a;
`else
        effA = useAcc ? a : a;
`endif
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        while (bus.cmd_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL accept timeout: got cmd_ready=%b, expected 1", bus.cmd_ready);
            bus.cmd_valid = 1'b0;
            tick();
            return;
        end
        e = aluRef(effA, b, op);
        expQ.push_back(e);
        accModel    = e.result;
        modelCount  = modelCount + 8'd1;
        modelSticky = clrAtCapture ? e.flags : (modelSticky | e.flags);
        tick();
        bus.cmd_valid = 1'b0;
        if (clrAtCapture) begin
            clr_sticky = 1'b1;
            tick();
            clr_sticky = 1'b0;
        end
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while ((busy !== 1'b0 || expQ.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL idle timeout: got busy=%b pending=%0d, expected idle", busy, expQ.size());
        end
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n       = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_a     = 4'd0;
        bus.cmd_b     = 4'd0;
        bus.cmd_op    = 3'd0;
`ifdef ALU_SEQ_ACC_EN
        bus.cmd_use_acc = 1'b0;
`endif
        clr_sticky = 1'b0;
        lastRsp    = 8'd0;
        readyMode  = 0;
        #2;
        doReset();

        checkOutput("reset rsp_valid", 16'(bus.rsp_valid), 16'd0);
        checkOutput("reset cmd_ready", 16'(bus.cmd_ready), 16'd1);
        checkOutput("reset sticky", 16'(sticky_flags), 16'd0);
        checkOutput("reset op_count", 16'(op_count), 16'd0);
        checkOutput("reset busy", 16'(busy), 16'd0);

        applyStimulus(4'd0, 4'd0, 3'd0, 1'b0, 1'b0);
        waitIdle();
        checkOutput("not a", 16'(lastRsp), 16'h00F4);
        applyStimulus(4'd5, 4'd3, 3'd6, 1'b0, 1'b0);
        waitIdle();
        checkOutput("add 5+3", 16'(lastRsp), 16'h0085);
        checkOutput("sticky after add", 16'(sticky_flags), 16'h0005);
        checkOutput("op_count two", 16'(op_count), 16'd2);

        // Response held under backpressure, then released.
        readyMode = 1;
        applyStimulus(4'd7, 4'd1, 3'd7, 1'b0, 1'b0);
        for (int n = 0; n < 20 && bus.rsp_valid !== 1'b1; n++) tick();
        repeat (5) tick();
        checkOutput("held rsp_valid", 16'(bus.rsp_valid), 16'd1);
        checkOutput("held rsp_result", 16'(bus.rsp_result), 16'h0006);
        checkOutput("held rsp_flags", 16'(bus.rsp_flags), 16'h0008);
        checkOutput("held cmd_ready", 16'(bus.cmd_ready), 16'd0);
        readyMode = 0;
        tick();
        checkOutput("released busy", 16'(busy), 16'd0);
        checkOutput("released cmd_ready", 16'(bus.cmd_ready), 16'd1);
        checkOutput("sub 7-1", 16'(lastRsp), 16'h0068);

        // Reset while the command is in EXEC drops it.
        applyStimulus(4'd3, 4'd2, 3'd4, 1'b0, 1'b0);
        checkOutput("exec busy", 16'(busy), 16'd1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        resetModel();
        checkOutput("midreset op_count", 16'(op_count), 16'd0);
        checkOutput("midreset cmd_ready", 16'(bus.cmd_ready), 16'd1);
        repeat (3) tick();
        checkOutput("midreset rsp_valid", 16'(bus.rsp_valid), 16'd0);
        checkOutput("midreset busy", 16'(busy), 16'd0);

        applyStimulus(4'd5, 4'd3, 3'd2, 1'b0, 1'b0);
        waitIdle();
        checkOutput("and 5&3", 16'(lastRsp), 16'h0010);
        applyStimulus(4'd5, 4'd3, 3'd6, 1'b0, 1'b0);
        waitIdle();
        checkOutput("sticky before clear", 16'(sticky_flags), 16'h0005);
        applyStimulus(4'd0, 4'd0, 3'd0, 1'b0, 1'b1);
        waitIdle();
        checkOutput("clear with capture", 16'(sticky_flags), 16'h0004);
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        modelSticky = 4'd0;
        checkOutput("clear alone", 16'(sticky_flags), 16'h0000);

`ifdef ALU_SEQ_ACC_EN
        doReset();
        applyStimulus(4'd5, 4'd3, 3'd6, 1'b0, 1'b0);
        applyStimulus(4'd9, 4'd1, 3'd7, 1'b1, 1'b0);
        waitIdle();
        checkOutput("acc sub", 16'(lastRsp.result), 16'h0007);
`endif

        // Random operations with random response backpressure.
        readyMode = 2;
        for (int i = 0; i < 60; i++) begin
            applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                          3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b0);
            if ($urandom_range(0, 3) == 0) tick();
        end
        waitIdle();
        readyMode = 0;
        checkOutput("random sticky", 16'(sticky_flags), 16'(modelSticky));
        checkOutput("random op_count", 16'(op_count), 16'(modelCount));

        // Counter wrap after all-ones.
        doReset();
        for (int i = 0; i < 255; i++) begin
            applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                          3'($urandom_range(0, 7)), 1'b0, 1'b0);
        end
        waitIdle();
        checkOutput("op_count all ones", 16'(op_count), 16'd255);
        applyStimulus(4'd1, 4'd1, 3'd6, 1'b0, 1'b0);
        waitIdle();
        checkOutput("op_count wrap", 16'(op_count), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
